// File: rtl/instr_fetch_master.sv
// -----------------------------------------------------------------------------
// instr_fetch_master
//
// Instruction-fetch initiator. Walks a program counter in DATA_WIDTH/8-byte
// steps, issues one read per cycle to the instruction memory, buffers the
// returned words (with their byte addresses) in a small FIFO and presents the
// FIFO head to the core over a valid/ready handshake. A one-cycle branch
// strobe flushes everything and restarts fetching at the branch target.
// Address MSB=1 is boot ROM, MSB=0 is instruction RAM; the memory decodes
// that itself, so nothing here treats the boundary specially.
//
// Optional build macro: FETCH_MISALIGN_ERR_EN
//   defined   : a branch to a non word-aligned target raises the sticky
//               misalign_err_o and halts fetching until a word-aligned branch.
//   undefined : the low target bits are silently zeroed, misalign_err_o = 0.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   fetch_en_i      : permits new memory requests
//   branch_i        : one-cycle redirect strobe
//   branch_addr_i   : redirect target byte address
//   instr_valid_o   : FIFO head is valid
//   instr_ready_i   : core accepts the FIFO head
//   instr_rdata_o   : FIFO head instruction word
//   instr_addr_o    : FIFO head byte address
//   misalign_err_o  : sticky misaligned-branch flag
//   mem_en_o        : memory request strobe
//   mem_addr_o      : memory request byte address
//   mem_we_o        : always 0 (read-only initiator)
//   mem_be_o        : always all-ones
//   mem_wdata_o     : always 0
//   mem_rdata_i     : read data, valid the cycle after mem_en_o
// -----------------------------------------------------------------------------
module instr_fetch_master #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 16'h8000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_en_i,
  input  logic                      branch_i,
  input  logic [ADDR_WIDTH-1:0]     branch_addr_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [DATA_WIDTH-1:0]     instr_rdata_o,
  output logic [ADDR_WIDTH-1:0]     instr_addr_o,
  output logic                      misalign_err_o,
  output logic                      mem_en_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [CNT_W:0]        DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  halt_s;
  logic                  pop_raw_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;
  logic [CNT_W:0]        occ_s;

`ifdef FETCH_MISALIGN_ERR_EN
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   err_q, err_d;
  logic   misalign_s;

  // RUN/HALT next state: only a branch moves the FSM; its alignment decides where.
  always_comb begin
    misalign_s = ((branch_addr_i & ALIGN_MASK) != {ADDR_WIDTH{1'b0}});
    state_d    = state_q;
    err_d      = err_q;
    case (state_q)
      ST_RUN, ST_HALT: begin
        if (branch_i) begin
          if (misalign_s) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            err_d   = 1'b0;
          end
        end else begin
          state_d = state_q;
          err_d   = err_q;
        end
      end
      default: begin
        state_d = ST_RUN;
        err_d   = 1'b0;
      end
    endcase
  end

  // RUN/HALT state and sticky error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign halt_s         = (state_q == ST_HALT);
  assign misalign_err_o = err_q;
`else
  assign halt_s         = 1'b0;
  assign misalign_err_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request issue and handshake qualifiers
  // ---------------------------------------------------------------------------
  // A request is only issued if the FIFO is certain to have room for its
  // response next cycle: current words plus the one in flight, less the word
  // being popped now. That is what makes overflow impossible.
  always_comb begin
    pop_raw_s = (count_q != {CNT_W{1'b0}}) & instr_ready_i;
    occ_s     = {1'b0, count_q} + (CNT_W + 1)'(pend_q) - (CNT_W + 1)'(pop_raw_s);
    issue_s   = fetch_en_i & ~branch_i & ~halt_s & (occ_s < DEPTH_C);
    pop_s     = pop_raw_s & ~branch_i;
    push_s    = pend_q & ~branch_i;
  end

  // Program counter and in-flight tracking; branch overrides everything.
  always_comb begin
    pc_d        = pc_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    if (branch_i) begin
      pc_d   = branch_addr_i & ~ALIGN_MASK;
      pend_d = 1'b0;
    end else if (issue_s) begin
      pc_d        = pc_q + STRIDE;
      pend_d      = 1'b1;
      pend_addr_d = pc_q;
    end else begin
      pc_d   = pc_q;
      pend_d = 1'b0;
    end
  end

  // FIFO next state: branch clears it; otherwise push the returning word and/or pop the head.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (branch_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_data_d[wr_ptr_q] = mem_rdata_i;
        fifo_addr_d[wr_ptr_q] = pend_addr_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch datapath registers; reset also zeroes the storage so the head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= BOOT_ADDR;
      pend_q      <= 1'b0;
      pend_addr_q <= {ADDR_WIDTH{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= {DATA_WIDTH{1'b0}};
        fifo_addr_q[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
        fifo_addr_q[i] <= fifo_addr_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Head outputs come straight from FIFO storage, so mem_rdata_i never reaches
  // instr_rdata_o in the same cycle.
  assign instr_valid_o = (count_q != {CNT_W{1'b0}});
  assign instr_rdata_o = fifo_data_q[rd_ptr_q];
  assign instr_addr_o  = fifo_addr_q[rd_ptr_q];

  assign mem_en_o    = issue_s;
  assign mem_addr_o  = pc_q;
  assign mem_we_o    = 1'b0;
  assign mem_be_o    = {BYTES{1'b1}};
  assign mem_wdata_o = {DATA_WIDTH{1'b0}};

endmodule

// File: doc/instr_fetch_master.md
Name: instr_fetch_master

Overview:
Initiator for the instruction-memory port. Drives en/addr/we/be/wdata and consumes rdata, which the memory returns exactly one cycle after an enabled request. The address space is split on the address MSB: MSB=1 selects boot ROM, MSB=0 selects instruction RAM. Issues sequential word fetches from a program counter and buffers returned words in a small FIFO. Presents the buffered words to the core over a valid/ready handshake, and redirects on branch.

Parameters:
ADDR_WIDTH, 16, memory byte-address width; MSB=1 selects boot ROM.
DATA_WIDTH, 32, instruction word width; the fetch stride is DATA_WIDTH/8 bytes.
FIFO_DEPTH, 4, number of buffered instruction words; must be a power of 2 and at least 2.
BOOT_ADDR, 16'h8000, program counter value after reset.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
fetch_en_i  in  1  when 1, new memory requests may be issued.
branch_i  in  1  one-cycle redirect strobe.
branch_addr_i  in  ADDR_WIDTH  redirect target byte address.
instr_valid_o  out  1  FIFO head is valid.
instr_ready_i  in  1  core accepts the FIFO head.
instr_rdata_o  out  DATA_WIDTH  FIFO head instruction word.
instr_addr_o  out  ADDR_WIDTH  byte address of the FIFO head word.
misalign_err_o  out  1  sticky misaligned-branch flag (see Optional Feature).
mem_en_o  out  1  memory request strobe.
mem_addr_o  out  ADDR_WIDTH  request byte address.
mem_we_o  out  1  constant 0.
mem_be_o  out  DATA_WIDTH/8  constant all-ones.
mem_wdata_o  out  DATA_WIDTH  constant 0.
mem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after mem_en_o=1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=BOOT_ADDR; FIFO empty; no request in flight.
  - mem_en_o=0, instr_valid_o=0, misalign_err_o=0.
  - instr_rdata_o and instr_addr_o are 0.
  - Reset asserted mid-operation discards all in-flight and buffered data.
- State: RUN/HALT bit plus a request-in-flight flag (pend) with its address (pend_addr). HALT is entered only via the Optional Feature.
- Request issue (combinational):
  - mem_en_o = fetch_en_i & ~branch_i & ~HALT & (count + pend + (pop ? -1 : 0) < FIFO_DEPTH).
  - mem_addr_o = pc.
  - On issue: pc <= pc + DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH (0xFFFC -> 0x0000).
  - On issue: pend <= 1, pend_addr <= pc; otherwise pend <= 0.
- Response: when pend=1 and no branch_i this cycle, push {mem_rdata_i, pend_addr} into the FIFO. Space is guaranteed by the issue rule, so the FIFO never overflows.
- Pop: when instr_valid_o & instr_ready_i. Push and pop in the same cycle leave count unchanged.
- instr_valid_o = (count != 0). Output data is registered in the FIFO; there is no combinational path from mem_rdata_i to instr_rdata_o.
- Throughput: with instr_ready_i held at 1, one word per cycle is delivered after 2 cycles of initial latency (request, then push; valid in the following cycle).
- Branch (branch_i=1):
  - Highest priority. The FIFO is cleared and any pop that cycle is ignored.
  - The in-flight response is dropped; pend <= 0.
  - pc <= branch_addr_i with its low log2(DATA_WIDTH/8) bits zeroed.
  - No request is issued in the branch cycle; the first request at the target goes out the next cycle.
- Crossing the boot-ROM/RAM boundary through sequential increment or branch needs no special handling. The memory side registers its own select.
- fetch_en_i=0: no new requests. The in-flight response is still pushed, and the FIFO continues to drain.

Optional Feature:
Macro: FETCH_MISALIGN_ERR_EN.
- Defined:
  - A branch whose target has any nonzero low bits sets misalign_err_o=1 (sticky) and enters HALT. No requests are issued and the FIFO is cleared.
  - Only a later word-aligned branch clears misalign_err_o, returns to RUN and fetches the target.
- Not defined: low bits are silently zeroed, misalign_err_o is tied to 0, and there is no HALT state.

Test Plan:
- Reset, fetch_en_i=1, instr_ready_i=1; memory returns data = address -> mem_addr_o requests 0x8000, 0x8004, 0x8008, ... on consecutive cycles; instr_addr_o/instr_rdata_o deliver 0x8000, 0x8004, ... in order, one per cycle, after 2-cycle latency.
- instr_ready_i=0 with FIFO_DEPTH=4 -> exactly 4 requests issued, then mem_en_o=0. instr_ready_i=1 for 1 cycle -> exactly one new request, and no word is lost or duplicated.
- branch_i to 0x0100 while one request is in flight and 3 words are buffered -> instr_valid_o=0 the next cycle, the stale word is never presented, next request is 0x0100, first delivered word has address 0x0100.
- pc=0xFFFC sequential -> next request 0x0000, delivered in order.
- Branch in the same cycle as pop and push -> FIFO empty afterwards; no response from the branch cycle appears.
- Macro defined: branch to 0x0102 -> misalign_err_o=1, mem_en_o=0 for 10 cycles; branch to 0x0200 -> misalign_err_o=0, request 0x0200. Macro undefined: branch to 0x0102 -> request 0x0100, misalign_err_o=0.
